// File: rtl/bcd_time_counter_pkg.sv
// ----------------------------------------------------------------------------
// bcd_time_counter_pkg
//   Shared definitions for the minutes:seconds BCD timekeeping block:
//   FSM state encoding, display blink-select codes and BCD field limits.
// ----------------------------------------------------------------------------
package bcd_time_counter_pkg;

  typedef enum logic [1:0] {
    ST_STOP   = 2'b00,
    ST_RUN    = 2'b01,
    ST_SETMIN = 2'b10,
    ST_SETSEC = 2'b11
  } state_e;

  localparam logic [1:0] FLICK_NONE = 2'b00;
  localparam logic [1:0] FLICK_MIN  = 2'b10;
  localparam logic [1:0] FLICK_SEC  = 2'b01;

  localparam logic [7:0] SEC_MAX = 8'h59;
  localparam logic [7:0] MIN_MAX = 8'h99;

  // Blink select shown by the display for a given state.
  function automatic logic [1:0] flick_of(input state_e s);
    case (s)
      ST_SETMIN: flick_of = FLICK_MIN;
      ST_SETSEC: flick_of = FLICK_SEC;
      default:   flick_of = FLICK_NONE;
    endcase
  endfunction

endpackage

// File: rtl/bcd_time_counter_bcd2.sv
// ----------------------------------------------------------------------------
// bcd2_counter
//   Two-digit BCD up/down counter with wrap at MAX (up) and at 00 (down).
//   Ports:
//     clk       system clock
//     i_clr     synchronous load-zero (highest priority)
//     i_inc     count up one step
//     i_dec     count down one step (ignored when i_inc is set)
//     o_val     registered BCD value {tens, ones}
//     o_carry   high in the cycle an increment wraps MAX -> 00
//     o_borrow  high in the cycle a decrement wraps 00 -> MAX
// ----------------------------------------------------------------------------
module bcd2_counter #(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       clk,
  input  logic       i_clr,
  input  logic       i_inc,
  input  logic       i_dec,
  output logic [7:0] o_val,
  output logic       o_carry,
  output logic       o_borrow
);

  logic [7:0] r_val;
  logic [7:0] w_val_inc;
  logic [7:0] w_val_dec;

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_val_inc = r_val;
    w_val_dec = r_val;

    if (r_val == MAX)
      w_val_inc = 8'h00;
    else if (r_val[3:0] == 4'd9)
      w_val_inc = {r_val[7:4] + 4'd1, 4'd0};
    else
      w_val_inc = {r_val[7:4], r_val[3:0] + 4'd1};

    if (r_val == 8'h00)
      w_val_dec = MAX;
    else if (r_val[3:0] == 4'd0)
      w_val_dec = {r_val[7:4] - 4'd1, 4'd9};
    else
      w_val_dec = {r_val[7:4], r_val[3:0] - 4'd1};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (i_clr)
      r_val <= 8'h00;
    else if (i_inc)
      r_val <= w_val_inc;
    else if (i_dec)
      r_val <= w_val_dec;
  end

  assign o_val    = r_val;
  assign o_carry  = i_inc && (r_val == MAX);
  assign o_borrow = i_dec && !i_inc && (r_val == 8'h00);

endmodule

// File: rtl/bcd_time_counter.sv
// ----------------------------------------------------------------------------
// bcd_time_counter
//   Minutes:seconds BCD timer feeding the seven-segment display driver.
//   Counts up or down once per TICK_DIV clocks, stops with a sticky done flag
//   at 99:59 (up) or 00:00 (down), and offers a button-driven set mode.
//   Ports:
//     clk      system clock
//     rst      synchronous active-high reset
//     mode_i   pulse: STOP -> SET_MIN -> SET_SEC -> STOP
//     start_i  pulse: start / pause
//     inc_i    pulse: increment the field being edited
//     dir_i    level: 0 = count up, 1 = count down
//     min_o    minutes BCD 00-99
//     sec_o    seconds BCD 00-59
//     flick_o  blink select: 10 minutes, 01 seconds, 00 none
//     done_o   sticky end-of-count flag
// ----------------------------------------------------------------------------
module bcd_time_counter
  import bcd_time_counter_pkg::*;
#(
  parameter int TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_i,
  input  logic       start_i,
  input  logic       inc_i,
  input  logic       dir_i,
  output logic [7:0] min_o,
  output logic [7:0] sec_o,
  output logic [1:0] flick_o,
  output logic       done_o
);

  localparam int              PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);

  state_e        r_state, w_state_nxt;
  logic [PW-1:0] r_presc;
  logic          r_done, w_done_nxt;
  logic [1:0]    r_flick;

  logic [7:0] w_min, w_sec;
  logic       w_tick;
  logic       w_at_max, w_at_zero, w_reach_max, w_reach_zero;
  logic       w_sec_inc, w_sec_dec, w_min_inc_set, w_run_up, w_run_dn;
  logic       w_min_inc, w_min_dec;
  logic       w_sec_carry, w_sec_borrow, w_min_carry, w_min_borrow;
  logic       w_min_wrap_unused;

  assign w_tick       = (r_state == ST_RUN) && (r_presc == PRESC_LAST);
  assign w_at_max     = (w_min == MIN_MAX) && (w_sec == SEC_MAX);
  assign w_at_zero    = (w_min == 8'h00) && (w_sec == 8'h00);
  // One step away from the limit: this tick lands on it and must stop.
  assign w_reach_max  = (w_min == MIN_MAX) && (w_sec == 8'h58);
  assign w_reach_zero = (w_min == 8'h00) && (w_sec == 8'h01);

  always_comb begin
    w_state_nxt   = r_state;
    w_done_nxt    = r_done;
    w_sec_inc     = 1'b0;
    w_sec_dec     = 1'b0;
    w_min_inc_set = 1'b0;
    w_run_up      = 1'b0;
    w_run_dn      = 1'b0;

    case (r_state)
      ST_STOP: begin
        if (start_i && !(dir_i ? w_at_zero : w_at_max)) begin
          w_state_nxt = ST_RUN;
          w_done_nxt  = 1'b0;
        end else if (mode_i) begin
          w_state_nxt = ST_SETMIN;
          w_done_nxt  = 1'b0;
        end
      end

      ST_RUN: begin
        if (start_i) begin
          w_state_nxt = ST_STOP;
        end else if (w_tick) begin
          // A direction flip mid-run can leave us sitting on the limit of the
          // new direction; stop there rather than wrapping.
          if (!dir_i) begin
            if (w_at_max) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = ST_STOP;
            end else begin
              w_run_up  = 1'b1;
              w_sec_inc = 1'b1;
              if (w_reach_max) begin
                w_done_nxt  = 1'b1;
                w_state_nxt = ST_STOP;
              end
            end
          end else begin
            if (w_at_zero) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = ST_STOP;
            end else begin
              w_run_dn  = 1'b1;
              w_sec_dec = 1'b1;
              if (w_reach_zero) begin
                w_done_nxt  = 1'b1;
                w_state_nxt = ST_STOP;
              end
            end
          end
        end
      end

      ST_SETMIN: begin
        w_min_inc_set = inc_i;
        if (mode_i) w_state_nxt = ST_SETSEC;
      end

      ST_SETSEC: begin
        w_sec_inc = inc_i;
        if (mode_i) w_state_nxt = ST_STOP;
      end

      default: w_state_nxt = ST_STOP;
    endcase
  end

  // Seconds carry/borrow ripples into minutes only while running; editing
  // seconds wraps 59 -> 00 without touching minutes.
  assign w_min_inc = w_min_inc_set | (w_run_up & w_sec_carry);
  assign w_min_dec = w_run_dn & w_sec_borrow;

  // Minute wrap only happens while editing; nothing downstream consumes it.
  assign w_min_wrap_unused = w_min_carry | w_min_borrow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_STOP;
      r_done  <= 1'b0;
      r_flick <= FLICK_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      r_flick <= flick_of(w_state_nxt);
    end
  end

  // Cleared whenever RUN is left or not yet entered, so a pause discards
  // the partial second and a restart waits a full TICK_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst || (r_state != ST_RUN) || (w_state_nxt != ST_RUN) || w_tick)
      r_presc <= '0;
    else
      r_presc <= r_presc + PW'(1);
  end

  bcd2_counter #(.MAX(SEC_MAX)) u_sec (
    .clk      (clk),
    .i_clr    (rst),
    .i_inc    (w_sec_inc),
    .i_dec    (w_sec_dec),
    .o_val    (w_sec),
    .o_carry  (w_sec_carry),
    .o_borrow (w_sec_borrow)
  );

  bcd2_counter #(.MAX(MIN_MAX)) u_min (
    .clk      (clk),
    .i_clr    (rst),
    .i_inc    (w_min_inc),
    .i_dec    (w_min_dec),
    .o_val    (w_min),
    .o_carry  (w_min_carry),
    .o_borrow (w_min_borrow)
  );

  assign min_o   = w_min;
  assign sec_o   = w_sec;
  assign flick_o = r_flick;
  assign done_o  = r_done;

endmodule

// File: tb/tb_bcd_time_counter.sv
// ----------------------------------------------------------------------------
// tb_bcd_time_counter
//   Directed scenarios followed by random button traffic, every cycle compared
//   against a reference model that keeps the time as plain integer minutes and
//   seconds.
// ----------------------------------------------------------------------------
module tb_bcd_time_counter;

  localparam int TD = 4;

  localparam int M_STOP   = 0;
  localparam int M_RUN    = 1;
  localparam int M_SETMIN = 2;
  localparam int M_SETSEC = 3;
  localparam int T_LIMIT  = 99 * 60 + 59;

  logic       clk = 1'b0;
  logic       rst, mode_i, start_i, inc_i, dir_i;
  logic [7:0] min_o, sec_o;
  logic [1:0] flick_o;
  logic       done_o;

  int n_run, n_fail;

  // Reference model
  int ms, mp, mm, mss;
  bit md;
  logic dir;

  bcd_time_counter #(.TICK_DIV(TD)) dut (
    .clk     (clk),
    .rst     (rst),
    .mode_i  (mode_i),
    .start_i (start_i),
    .inc_i   (inc_i),
    .dir_i   (dir_i),
    .min_o   (min_o),
    .sec_o   (sec_o),
    .flick_o (flick_o),
    .done_o  (done_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic logic [7:0] flick_exp();
    if (ms == M_SETMIN) return 8'h02;
    if (ms == M_SETSEC) return 8'h01;
    return 8'h00;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clk(input logic r, input logic m, input logic s,
                           input logic i, input logic d);
    int total;
    total = mm * 60 + mss;
    if (r) begin
      ms = M_STOP; mp = 0; mm = 0; mss = 0; md = 0;
    end else begin
      case (ms)
        M_STOP: begin
          if (s && !(d ? (total == 0) : (total == T_LIMIT))) begin
            ms = M_RUN; md = 0;
          end else if (m) begin
            ms = M_SETMIN; md = 0;
          end
        end
        M_RUN: begin
          if (s) begin
            ms = M_STOP; mp = 0;
          end else if (mp == TD - 1) begin
            mp = 0;
            if (!d) begin
              if (total == T_LIMIT) begin md = 1; ms = M_STOP; end
              else begin
                total++;
                if (total == T_LIMIT) begin md = 1; ms = M_STOP; end
              end
            end else begin
              if (total == 0) begin md = 1; ms = M_STOP; end
              else begin
                total--;
                if (total == 0) begin md = 1; ms = M_STOP; end
              end
            end
            mm = total / 60; mss = total % 60;
          end else begin
            mp++;
          end
        end
        M_SETMIN: begin
          if (i) mm = (mm + 1) % 100;
          if (m) ms = M_SETSEC;
        end
        default: begin
          if (i) mss = (mss + 1) % 60;
          if (m) ms = M_STOP;
        end
      endcase
    end
  endtask

  // Drive one cycle of inputs, advance the model, compare after the edge.
  task automatic step(input logic r, input logic m, input logic s, input logic i);
    rst = r; mode_i = m; start_i = s; inc_i = i; dir_i = dir;
    model_clk(r, m, s, i, dir);
    @(posedge clk); #1;
    check("min", min_o, to_bcd(mm));
    check("sec", sec_o, to_bcd(mss));
    check("flick", {6'b0, flick_o}, flick_exp());
    check("done", {7'b0, done_o}, {7'b0, md});
    mode_i = 1'b0; start_i = 1'b0; inc_i = 1'b0; rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0);
  endtask

  task automatic set_value(input int tm, input int ts);
    step(0, 1, 0, 0);
    for (int k = 0; k < 120 && mm != tm; k++) step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    for (int k = 0; k < 120 && mss != ts; k++) step(0, 0, 0, 1);
    step(0, 1, 0, 0);
  endtask

  initial begin
    n_run = 0; n_fail = 0;
    dir = 1'b0;
    rst = 1'b1; mode_i = 1'b0; start_i = 1'b0; inc_i = 1'b0; dir_i = 1'b0;
    ms = M_STOP; mp = 0; mm = 0; mss = 0; md = 0;

    // 1. reset, then first ticks
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rst_min", min_o, 8'h00);
    check("rst_sec", sec_o, 8'h00);
    check("rst_flick", {6'b0, flick_o}, 8'h00);
    check("rst_done", {7'b0, done_o}, 8'h00);
    step(0, 0, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      idle(1);
      check((k == 4) ? "t1_first_tick" : "t1_wait", sec_o, (k == 4) ? 8'h01 : 8'h00);
    end
    idle(4);
    check("t1_second_tick", sec_o, 8'h02);
    step(0, 0, 1, 0);

    // 2. seconds carry into minutes, stop at 99:59
    set_value(0, 59);
    step(0, 0, 1, 0);
    idle(4);
    check("t2_carry_min", min_o, 8'h01);
    check("t2_carry_sec", sec_o, 8'h00);
    step(0, 0, 1, 0);
    set_value(98, 59);
    step(0, 0, 1, 0);
    idle(60 * TD);
    check("t2_max_min", min_o, 8'h99);
    check("t2_max_sec", sec_o, 8'h59);
    check("t2_max_done", {7'b0, done_o}, 8'h01);
    step(0, 0, 1, 0);
    idle(TD);
    check("t2_start_ignored_sec", sec_o, 8'h59);
    check("t2_start_ignored_done", {7'b0, done_o}, 8'h01);

    // 3. count down to 00:00
    set_value(1, 0);
    dir = 1'b1;
    step(0, 0, 1, 0);
    idle(TD);
    check("t3_borrow_min", min_o, 8'h00);
    check("t3_borrow_sec", sec_o, 8'h59);
    idle(59 * TD);
    check("t3_zero_sec", sec_o, 8'h00);
    check("t3_zero_done", {7'b0, done_o}, 8'h01);
    step(0, 0, 1, 0);
    idle(TD);
    check("t3_start_ignored_done", {7'b0, done_o}, 8'h01);
    step(0, 1, 0, 0);
    check("t3_mode_clears_done", {7'b0, done_o}, 8'h00);
    check("t3_mode_flick", {6'b0, flick_o}, 8'h02);

    // 4. set-mode wraps
    for (int k = 0; k < 100; k++) step(0, 0, 0, 1);
    check("t4_min_wrap", min_o, 8'h00);
    step(0, 1, 0, 0);
    check("t4_flick_sec", {6'b0, flick_o}, 8'h01);
    for (int k = 0; k < 59; k++) step(0, 0, 0, 1);
    check("t4_sec_59", sec_o, 8'h59);
    step(0, 0, 0, 1);
    check("t4_sec_wrap", sec_o, 8'h00);
    check("t4_sec_wrap_min", min_o, 8'h00);
    step(0, 1, 0, 0);
    check("t4_flick_none", {6'b0, flick_o}, 8'h00);

    // 5. buttons ignored in RUN, pause discards partial second
    dir = 1'b0;
    set_value(5, 10);
    step(0, 0, 1, 0);
    step(0, 1, 0, 1);
    check("t5_run_mode_flick", {6'b0, flick_o}, 8'h00);
    check("t5_run_inc_min", min_o, 8'h05);
    step(0, 0, 1, 0);
    idle(6);
    check("t5_paused_sec", sec_o, 8'h10);
    step(0, 0, 1, 0);
    idle(3);
    check("t5_restart_wait", sec_o, 8'h10);
    idle(1);
    check("t5_restart_tick", sec_o, 8'h11);

    // 6. start beats mode, reset mid-run
    step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    check("t6_start_priority_flick", {6'b0, flick_o}, 8'h00);
    idle(TD);
    check("t6_start_priority_tick", sec_o, 8'h12);
    step(0, 0, 1, 0);
    set_value(12, 34);
    step(0, 0, 1, 0);
    idle(2);
    check("t6_pre_rst_min", min_o, 8'h12);
    step(1, 0, 0, 0);
    check("t6_rst_min", min_o, 8'h00);
    check("t6_rst_sec", sec_o, 8'h00);
    idle(TD + 1);
    check("t6_rst_stopped", sec_o, 8'h00);

    // Random button traffic
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 49) == 0) dir = ~dir;
      step(logic'($urandom_range(0, 499) == 0),
           logic'($urandom_range(0, 19) == 0),
           logic'($urandom_range(0, 24) == 0),
           logic'($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
